// File: rtl/dual_port_ssram_be.sv
// dual_port_ssram_be: byte-enabled dual-port synchronous SRAM with read pipeline, collision flag and clear sequencer
//   clock_i/n_reset_i            : rising-edge clock, asynchronous active-low reset
//   enable_x_i/write_enable_x_i  : access request and write select per port (x = a, b)
//   byte_enable_x_i              : byte-lane write mask, bit i covers data[8i+7:8i]
//   address_x_i/data_in_x_i      : word address and write data
//   data_out_x_o/valid_x_o       : read data (held between results) and one-cycle result strobe
//   clear_request_i/busy_o       : start array clear, high while the clear runs
//   collision_o                  : one-cycle flag for overlapping same-address writes
module dual_port_ssram_be #(
  parameter int bitwidth    = 32,
  parameter int nrOfEntries = 512,
  parameter int readLatency = 1,
  parameter int writeFirst  = 0
) (
  input  logic                           clock_i,
  input  logic                           n_reset_i,
  input  logic                           enable_a_i,
  input  logic                           enable_b_i,
  input  logic                           write_enable_a_i,
  input  logic                           write_enable_b_i,
  input  logic [bitwidth/8-1:0]          byte_enable_a_i,
  input  logic [bitwidth/8-1:0]          byte_enable_b_i,
  input  logic [$clog2(nrOfEntries)-1:0] address_a_i,
  input  logic [$clog2(nrOfEntries)-1:0] address_b_i,
  input  logic [bitwidth-1:0]            data_in_a_i,
  input  logic [bitwidth-1:0]            data_in_b_i,
  output logic [bitwidth-1:0]            data_out_a_o,
  output logic [bitwidth-1:0]            data_out_b_o,
  output logic                           valid_a_o,
  output logic                           valid_b_o,
  input  logic                           clear_request_i,
  output logic                           busy_o,
  output logic                           collision_o
);
  localparam int aw = $clog2(nrOfEntries);
  localparam int nb = bitwidth / 8;
  localparam logic [aw-1:0] last = aw'(nrOfEntries - 1);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [aw-1:0] cnt_q, cnt_d;
  logic [bitwidth-1:0] mem [nrOfEntries];
  logic [1:0] en, we, acc, wr, rd;
  logic [nb-1:0] be [2];
  logic [aw-1:0] addr [2];
  logic [bitwidth-1:0] din [2];
  logic [bitwidth-1:0] rdata [2];
  logic [1:0] v1_q, v2_q;
  logic [bitwidth-1:0] d1_q [2];
  logic [bitwidth-1:0] d2_q [2];
  logic collision_q, collision_d;
  logic busy;
  assign busy = state_q == CLEAR;
  // index 0 is port A, index 1 is port B
  always_comb begin
    en = {enable_b_i, enable_a_i};
    we = {write_enable_b_i, write_enable_a_i};
    be[0] = byte_enable_a_i;
    be[1] = byte_enable_b_i;
    addr[0] = address_a_i;
    addr[1] = address_b_i;
    din[0] = data_in_a_i;
    din[1] = data_in_b_i;
    for (int p = 0; p < 2; p++) begin
      acc[p] = en[p] & ~busy;
      wr[p] = acc[p] & we[p] & (|be[p]);
      // a write with an empty mask is a no-op and yields no result
      rd[p] = acc[p] & (~we[p] | (|be[p]));
      // array read is pre-write, so the other port's same-cycle write is never visible
      rdata[p] = mem[addr[p]];
      for (int i = 0; i < nb; i++)
        if (writeFirst != 0 && we[p] && be[p][i]) rdata[p][8*i +: 8] = din[p][8*i +: 8];
    end
    collision_d = wr[0] & wr[1] & (addr[0] == addr[1]) & (|(be[0] & be[1]));
    state_d = state_q == IDLE ? (clear_request_i ? CLEAR : IDLE) : (cnt_q == last ? IDLE : CLEAR);
    cnt_d = state_q == IDLE || cnt_q == last ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clock_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      collision_q <= 1'b0;
      v1_q <= '0;
      v2_q <= '0;
      d1_q <= '{default: '0};
      d2_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      collision_q <= collision_d;
      v1_q <= rd;
      v2_q <= v1_q;
      for (int p = 0; p < 2; p++) begin
        if (rd[p]) d1_q[p] <= rdata[p];
        if (v1_q[p]) d2_q[p] <= d1_q[p];
      end
    end
  end
  // port B lanes are written first so port A wins lanes both ports enable
  always_ff @(posedge clock_i) begin
    if (busy) mem[cnt_q] <= '0;
    for (int p = 1; p >= 0; p--)
      for (int i = 0; i < nb; i++)
        if (wr[p] && be[p][i]) mem[addr[p]][8*i +: 8] <= din[p][8*i +: 8];
  end
  assign data_out_a_o = readLatency == 2 ? d2_q[0] : d1_q[0];
  assign data_out_b_o = readLatency == 2 ? d2_q[1] : d1_q[1];
  assign valid_a_o = readLatency == 2 ? v2_q[0] : v1_q[0];
  assign valid_b_o = readLatency == 2 ? v2_q[1] : v1_q[1];
  assign busy_o = busy;
  assign collision_o = collision_q;
endmodule

// File: tb/tb_dual_port_ssram_be.sv
// tb_dual_port_ssram_be: scoreboard bench driving a latency-1/read-first and a latency-2/write-first instance in lockstep
module tb_dual_port_ssram_be;
  localparam int N = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ea = 1'b0, eb = 1'b0, wa = 1'b0, wb = 1'b0, clr = 1'b0;
  logic [3:0] bea = '0, beb = '0, aa = '0, ab = '0;
  logic [31:0] da = '0, db = '0;
  logic [31:0] dout [2][2];
  logic [1:0] vld [2];
  logic [1:0] busy, coll;
  int errors = 0, checks = 0, cyc = 0;
  typedef struct {int due; int d; int p; logic [31:0] data;} exp_t;
  exp_t sb [$];
  logic [31:0] mem_m [N];
  logic busy_m = 1'b0;
  int cnt_m = 0;

  dual_port_ssram_be #(.bitwidth(32), .nrOfEntries(N), .readLatency(1), .writeFirst(0)) u0 (
    .clock_i(clk), .n_reset_i(rst_n),
    .enable_a_i(ea), .enable_b_i(eb), .write_enable_a_i(wa), .write_enable_b_i(wb),
    .byte_enable_a_i(bea), .byte_enable_b_i(beb), .address_a_i(aa), .address_b_i(ab),
    .data_in_a_i(da), .data_in_b_i(db), .data_out_a_o(dout[0][0]), .data_out_b_o(dout[0][1]),
    .valid_a_o(vld[0][0]), .valid_b_o(vld[0][1]), .clear_request_i(clr),
    .busy_o(busy[0]), .collision_o(coll[0]));

  dual_port_ssram_be #(.bitwidth(32), .nrOfEntries(N), .readLatency(2), .writeFirst(1)) u1 (
    .clock_i(clk), .n_reset_i(rst_n),
    .enable_a_i(ea), .enable_b_i(eb), .write_enable_a_i(wa), .write_enable_b_i(wb),
    .byte_enable_a_i(bea), .byte_enable_b_i(beb), .address_a_i(aa), .address_b_i(ab),
    .data_in_a_i(da), .data_in_b_i(db), .data_out_a_o(dout[1][0]), .data_out_b_o(dout[1][1]),
    .valid_a_o(vld[1][0]), .valid_b_o(vld[1][1]), .clear_request_i(clr),
    .busy_o(busy[1]), .collision_o(coll[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) begin
          int k;
          k = -1;
          foreach (sb[i]) if (sb[i].due == cyc && sb[i].d == d && sb[i].p == p) k = i;
          if (k >= 0) begin
            checks++;
            if (vld[d][p] !== 1'b1 || dout[d][p] !== sb[k].data) begin
              errors++;
              $display("FAIL read dut%0d port%0d cycle %0d: valid=%b data=%h, required valid=1 data=%h",
                       d, p, cyc, vld[d][p], dout[d][p], sb[k].data);
            end
            sb.delete(k);
          end else if (vld[d][p] !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL spurious_valid dut%0d port%0d cycle %0d: valid=%b, required 0", d, p, cyc, vld[d][p]);
          end
        end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  task automatic drive(input logic ea_, input logic wa_, input logic [3:0] bea_, input logic [3:0] aa_, input logic [31:0] da_,
                       input logic eb_, input logic wb_, input logic [3:0] beb_, input logic [3:0] ab_, input logic [31:0] db_,
                       input logic clr_);
    int t;
    t = cyc + 1;
    ea = ea_; wa = wa_; bea = bea_; aa = aa_; da = da_;
    eb = eb_; wb = wb_; beb = beb_; ab = ab_; db = db_; clr = clr_;
    if (!busy_m) begin
      if (ea_ && (!wa_ || bea_ != 4'd0)) begin
        sb.push_back('{t, 0, 0, mem_m[aa_]});
        sb.push_back('{t + 1, 1, 0, wa_ ? merge(mem_m[aa_], da_, bea_) : mem_m[aa_]});
      end
      if (eb_ && (!wb_ || beb_ != 4'd0)) begin
        sb.push_back('{t, 0, 1, mem_m[ab_]});
        sb.push_back('{t + 1, 1, 1, wb_ ? merge(mem_m[ab_], db_, beb_) : mem_m[ab_]});
      end
      if (eb_ && wb_) mem_m[ab_] = merge(mem_m[ab_], db_, beb_);
      if (ea_ && wa_) mem_m[aa_] = merge(mem_m[aa_], da_, bea_);
      if (clr_) begin
        busy_m = 1'b1;
        cnt_m = 0;
      end
    end else begin
      mem_m[cnt_m] = '0;
      if (cnt_m == N - 1) busy_m = 1'b0;
      else cnt_m++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask
  task automatic wr_a(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    drive(1'b1, 1'b1, be, a, d, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask
  task automatic rd_a(input logic [3:0] a);
    drive(1'b1, 1'b0, '0, a, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask
  task automatic wr_b(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, be, a, d, 1'b0);
  endtask
  task automatic rd_b(input logic [3:0] a);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0, a, '0, 1'b0);
  endtask

  task automatic check_quiet(input string tag);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (dout[d][0] !== 32'd0 || dout[d][1] !== 32'd0) begin
        errors++;
        $display("FAIL %s_data dut%0d: a=%h b=%h, required 0", tag, d, dout[d][0], dout[d][1]);
      end
      checks++;
      if (vld[d] !== 2'b00) begin errors++; $display("FAIL %s_valid dut%0d: %b, required 00", tag, d, vld[d]); end
      checks++;
      if (busy[d] !== 1'b0) begin errors++; $display("FAIL %s_busy dut%0d: %b, required 0", tag, d, busy[d]); end
      checks++;
      if (coll[d] !== 1'b0) begin errors++; $display("FAIL %s_collision dut%0d: %b, required 0", tag, d, coll[d]); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_clear(input int wr_at);
    int n;
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    checks++;
    if (busy[1] !== 1'b1) begin errors++; $display("FAIL clear_start busy=%b, required 1", busy[1]); end
    n = 0;
    while (n < 40 && busy[0] === 1'b1) begin
      n++;
      if (n == wr_at) wr_a(4'd2, 32'hDEADBEEF, 4'hF);
      else idle();
    end
    checks++;
    if (n != N || busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL clear_busy_cycles: %0d cycles, busy1=%b, required %0d cycles and 0", n, busy[1], N);
    end
  endtask

  task automatic test_clear();
    run_clear(0);
    for (int i = 0; i < N; i++) rd_a(4'(i));
    repeat (2) idle();
    for (int i = 0; i < N; i++) wr_a(4'(i), 32'h01010101 * 32'(i + 1), 4'hF);
    repeat (2) idle();
    run_clear(3);
    for (int i = 0; i < N; i++) rd_b(4'(i));
    repeat (2) idle();
  endtask

  task automatic test_byte_lane();
    wr_a(4'd5, 32'hAABBCCDD, 4'b1111);
    wr_a(4'd5, 32'h11223344, 4'b0101);
    wr_a(4'd5, 32'h99999999, 4'b0000);
    rd_a(4'd5);
    repeat (3) idle();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (dout[d][0] !== 32'hAA22CC44) begin
        errors++;
        $display("FAIL byte_lane_hold dut%0d: %h, required aa22cc44", d, dout[d][0]);
      end
    end
  endtask

  task automatic test_pipeline();
    for (int i = 1; i <= 3; i++) wr_a(4'(i), 32'(i), 4'hF);
    idle();
    for (int i = 1; i <= 3; i++) rd_a(4'(i));
    drive(1'b1, 1'b0, '0, 4'd3, '0, 1'b1, 1'b0, '0, 4'd1, '0, 1'b0);
    repeat (3) idle();
  endtask

  task automatic test_rdw();
    wr_a(4'd7, 32'hFFFFFFFF, 4'hF);
    repeat (2) idle();
    checks++;
    if (dout[0][0] !== 32'h0) begin errors++; $display("FAIL rdw_read_first: %h, required 00000000", dout[0][0]); end
    checks++;
    if (dout[1][0] !== 32'hFFFFFFFF) begin errors++; $display("FAIL rdw_write_first: %h, required ffffffff", dout[1][0]); end
    wr_b(4'd8, 32'h12345678, 4'b1100);
    repeat (2) idle();
  endtask

  task automatic test_collision();
    drive(1'b1, 1'b1, 4'b0011, 4'd9, 32'h11111111, 1'b1, 1'b1, 4'b0110, 4'd9, 32'h22222222, 1'b0);
    checks++;
    if (coll !== 2'b11) begin errors++; $display("FAIL collision_set: %b, required 11", coll); end
    idle();
    checks++;
    if (coll !== 2'b00) begin errors++; $display("FAIL collision_one_cycle: %b, required 00", coll); end
    rd_a(4'd9);
    repeat (2) idle();
    checks++;
    if (dout[0][0] !== 32'h00221111) begin errors++; $display("FAIL collision_merge: %h, required 00221111", dout[0][0]); end
    drive(1'b1, 1'b1, 4'b0001, 4'd10, 32'h33333333, 1'b1, 1'b1, 4'b1000, 4'd10, 32'h44444444, 1'b0);
    checks++;
    if (coll !== 2'b00) begin errors++; $display("FAIL collision_disjoint: %b, required 00", coll); end
    drive(1'b1, 1'b1, 4'hF, 4'd11, 32'h55555555, 1'b1, 1'b1, 4'hF, 4'd12, 32'h66666666, 1'b0);
    checks++;
    if (coll !== 2'b00) begin errors++; $display("FAIL collision_diff_addr: %b, required 00", coll); end
    drive(1'b1, 1'b0, '0, 4'd9, '0, 1'b1, 1'b1, 4'hF, 4'd9, 32'hCAFEF00D, 1'b0);
    checks++;
    if (coll !== 2'b00) begin errors++; $display("FAIL collision_read_write: %b, required 00", coll); end
    repeat (2) idle();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (dout[d][0] !== 32'h00221111) begin
        errors++;
        $display("FAIL cross_port_old dut%0d: %h, required 00221111", d, dout[d][0]);
      end
    end
    rd_a(4'd9);
    repeat (2) idle();
  endtask

  task automatic test_reset_mid_clear();
    for (int i = 0; i < N; i++) wr_a(4'(i), 32'hA5000000 + 32'(i * 3 + 1), 4'hF);
    repeat (2) idle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    repeat (5) idle();
    rst_n = 1'b0;
    #1;
    check_quiet("mid_clear_reset");
    busy_m = 1'b0;
    cnt_m = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) rd_a(4'(i));
    repeat (3) idle();
  endtask

  initial begin
    test_reset();
    test_clear();
    test_byte_lane();
    test_pipeline();
    test_rdw();
    test_collision();
    test_reset_mid_clear();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_results: %0d outstanding, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
